// File: rtl/motor_pkg.sv
// Shared types and constants for the motor drive sequencer.
//   seq_state_t  : sequencer FSM states
//   speed_lvl_t  : 2-bit PWM speed level (0 = stop, 3 = max)
//   fault_code_t : reported fault cause (FLT_NONE / FLT_EXT / FLT_WDOG)
//   step_toward  : one saturating level step from cur toward tgt
package motor_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RAMP    = 3'd1,
        RUN     = 3'd2,
        RAMP_DN = 3'd3,
        DEAD    = 3'd4,
        FAULT   = 3'd5
    } seq_state_t;

    typedef logic [1:0] speed_lvl_t;
    typedef logic [1:0] fault_code_t;

    localparam fault_code_t FLT_NONE = 2'd0;
    localparam fault_code_t FLT_EXT  = 2'd1;
    localparam fault_code_t FLT_WDOG = 2'd2;

    localparam speed_lvl_t LVL_STOP = 2'd0;

    // Moves one level toward tgt; returns cur unchanged once there, so the
    // level can never wrap past 0 or 3.
    function automatic speed_lvl_t step_toward(speed_lvl_t cur, speed_lvl_t tgt);
        speed_lvl_t nxt;
        nxt = cur;
        if (cur < tgt) begin
            nxt = cur + 2'd1;
        end else if (cur > tgt) begin
            nxt = cur - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/motor_drive_sequencer_if.sv
// Command channel into the motor drive sequencer.
//   cmd_valid : master has a command on cmd_level/cmd_dir
//   cmd_ready : sequencer can take a command this cycle
//   cmd_level : target speed level
//   cmd_dir   : target direction
// Handshake: a command transfers on the rising clk edge where cmd_valid and
// cmd_ready are both high. The master holds cmd_level/cmd_dir stable while
// cmd_valid is high and not yet accepted; cmd_ready does not depend on
// cmd_valid. There is no queueing: one command is in flight at most.
interface motor_drive_sequencer_if;
    import motor_pkg::*;

    logic       cmd_valid;
    logic       cmd_ready;
    speed_lvl_t cmd_level;
    logic       cmd_dir;

    modport master (output cmd_valid, output cmd_level, output cmd_dir, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_level, input cmd_dir, output cmd_ready);

endinterface

// File: rtl/seq_timer.sv
// Loadable down-counter used for the ramp step, dead-time and watchdog timers.
//   clk, rst  : clock, asynchronous active-high reset (count cleared)
//   load      : reload the counter with load_val this edge
//   load_val  : reload value (number of cycles until done)
//   done      : high during the cycle in which the count is 1, i.e. an action
//               keyed on done lands exactly load_val edges after the load edge
// After reaching 0 the counter parks there until the next load.
module seq_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == WIDTH'(1));

endmodule

// File: rtl/motor_drive_sequencer.sv
// Command sequencer in front of the bike-motor PWM stage.
// Takes speed/direction commands over a valid/ready channel and walks psw
// ({dir, level}) toward them one level per STEP_CYCLES. A direction change
// ramps to level 0, holds motor_en low for DEAD_CYCLES, flips dir, then
// ramps up. An external fault or missing heartbeat latches FAULT.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   cmd            : command channel (slave side)
//   heartbeat      : single-cycle keep-alive, required while motor_en is high
//   fault_in       : level-sensitive external fault
//   fault_clr      : single-cycle request to leave FAULT (needs fault_in low)
//   psw            : {dir, level[1:0]} to the PWM stage
//   motor_en       : PWM stage enable
//   busy           : ramp or reversal in progress
//   fault_latched  : sequencer is in FAULT
//   fault_code     : 0 none, 1 fault_in, 2 watchdog
//   state_dbg      : current FSM state
// All outputs come straight from registers.
module motor_drive_sequencer
    import motor_pkg::*;
#(
    parameter int STEP_CYCLES = 5000,
    parameter int DEAD_CYCLES = 2500,
    parameter int WDOG_CYCLES = 50000
) (
    input  logic                          clk,
    input  logic                          rst,
    motor_drive_sequencer_if.slave        cmd,
    input  logic                          heartbeat,
    input  logic                          fault_in,
    input  logic                          fault_clr,
    output logic [2:0]                    psw,
    output logic                          motor_en,
    output logic                          busy,
    output logic                          fault_latched,
    output logic [1:0]                    fault_code,
    output seq_state_t                    state_dbg
);

    localparam int MAX_SD  = (STEP_CYCLES > DEAD_CYCLES) ? STEP_CYCLES : DEAD_CYCLES;
    localparam int MAX_CYC = (MAX_SD > WDOG_CYCLES) ? MAX_SD : WDOG_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);

    seq_state_t  state, state_n;
    speed_lvl_t  lvl_q, lvl_n;
    logic        dir_q, dir_n;
    fault_code_t code_q, code_n;
    speed_lvl_t  tgt_level;
    logic        tgt_dir;
    logic        cmd_ready_q;
    logic        busy_q;
    logic        motor_en_q;
    logic        fault_latched_q;

    logic          accept;
    logic          step_done;
    logic          step_load;
    logic [TW-1:0] step_val;
    logic          wdog_done;
    logic          wdog_load;
    logic          wdog_expire;

    // Watchdog: held at full count while the stage is disabled, reloaded by
    // each heartbeat. A heartbeat on the expiry edge reloads instead of faulting.
    assign wdog_load   = heartbeat || !motor_en_q;
    assign wdog_expire = wdog_done && motor_en_q && !heartbeat;

    // A command that coincides with a fault is discarded: the fault wins.
    assign accept = cmd.cmd_valid && cmd_ready_q && !fault_in && !wdog_expire;

    // Step / dead-time timer restarts on every state entry, on each step, and
    // on an accept (which also covers an accept that leaves the state unchanged).
    assign step_load = (state_n != state) || accept || step_done;
    assign step_val  = (state_n == DEAD) ? TW'(DEAD_CYCLES) : TW'(STEP_CYCLES);

    seq_timer #(.WIDTH(TW)) u_step_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (step_load),
        .load_val (step_val),
        .done     (step_done)
    );

    seq_timer #(.WIDTH(TW)) u_wdog_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (wdog_load),
        .load_val (TW'(WDOG_CYCLES)),
        .done     (wdog_done)
    );

    always_comb begin
        state_n = state;
        lvl_n   = lvl_q;
        dir_n   = dir_q;
        code_n  = code_q;

        if (state != FAULT && fault_in) begin
            state_n = FAULT;
            lvl_n   = LVL_STOP;
            code_n  = FLT_EXT;
        end else if (state != FAULT && wdog_expire) begin
            state_n = FAULT;
            lvl_n   = LVL_STOP;
            code_n  = FLT_WDOG;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (cmd.cmd_dir != dir_q) begin
                            state_n = RAMP_DN;
                        end else if (cmd.cmd_level != LVL_STOP) begin
                            state_n = RAMP;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        state_n = (cmd.cmd_dir == dir_q) ? RAMP : RAMP_DN;
                    end
                end
                RAMP: begin
                    if (step_done) begin
                        lvl_n = step_toward(lvl_q, tgt_level);
                        if (lvl_n == tgt_level) begin
                            state_n = (tgt_level != LVL_STOP) ? RUN : IDLE;
                        end
                    end
                end
                RAMP_DN: begin
                    if (step_done) begin
                        lvl_n = step_toward(lvl_q, LVL_STOP);
                        if (lvl_n == LVL_STOP) begin
                            state_n = DEAD;
                        end
                    end
                end
                DEAD: begin
                    // The only place dir changes: level is 0 and motor_en low.
                    if (step_done) begin
                        dir_n   = tgt_dir;
                        state_n = (tgt_level != LVL_STOP) ? RAMP : IDLE;
                    end
                end
                FAULT: begin
                    if (fault_clr && !fault_in) begin
                        state_n = IDLE;
                        code_n  = FLT_NONE;
                    end
                end
                default: begin
                    state_n = IDLE;
                    lvl_n   = LVL_STOP;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            lvl_q           <= LVL_STOP;
            dir_q           <= 1'b0;
            code_q          <= FLT_NONE;
            tgt_level       <= LVL_STOP;
            tgt_dir         <= 1'b0;
            cmd_ready_q     <= 1'b1;
            busy_q          <= 1'b0;
            motor_en_q      <= 1'b0;
            fault_latched_q <= 1'b0;
        end else begin
            state           <= state_n;
            lvl_q           <= lvl_n;
            dir_q           <= dir_n;
            code_q          <= code_n;
            if (accept) begin
                tgt_level <= cmd.cmd_level;
                tgt_dir   <= cmd.cmd_dir;
            end
            cmd_ready_q     <= (state_n == IDLE) || (state_n == RUN);
            busy_q          <= (state_n == RAMP) || (state_n == RAMP_DN) || (state_n == DEAD);
            motor_en_q      <= (state_n == RAMP) || (state_n == RAMP_DN) || (state_n == RUN);
            fault_latched_q <= (state_n == FAULT);
        end
    end

    assign cmd.cmd_ready  = cmd_ready_q;
    assign psw            = {dir_q, lvl_q};
    assign motor_en       = motor_en_q;
    assign busy           = busy_q;
    assign fault_latched  = fault_latched_q;
    assign fault_code     = code_q;
    assign state_dbg      = state;

endmodule

// File: tb/tb_motor_drive_sequencer.sv
// Directed bench for motor_drive_sequencer (STEP=8, DEAD=4, WDOG=64).
// Inputs change 1 time unit after a rising edge; outputs are read at that
// same point, so each tick(n) lands just after the n-th following edge.
module tb_motor_drive_sequencer;
    import motor_pkg::*;

    logic       clk;
    logic       rst;
    logic       hb_auto;
    logic       hb_man;
    logic       hb_en;
    logic       heartbeat;
    logic       fault_in;
    logic       fault_clr;
    logic [2:0] psw;
    logic       motor_en;
    logic       busy;
    logic       fault_latched;
    logic [1:0] fault_code;
    seq_state_t state_dbg;

    int n_cmp;
    int n_err;
    int hb_cnt;

    motor_drive_sequencer_if cmd_if ();

    assign heartbeat = hb_auto | hb_man;

    motor_drive_sequencer #(
        .STEP_CYCLES (8),
        .DEAD_CYCLES (4),
        .WDOG_CYCLES (64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd           (cmd_if),
        .heartbeat     (heartbeat),
        .fault_in      (fault_in),
        .fault_clr     (fault_clr),
        .psw           (psw),
        .motor_en      (motor_en),
        .busy          (busy),
        .fault_latched (fault_latched),
        .fault_code    (fault_code),
        .state_dbg     (state_dbg)
    );

    // clock / reset-independent background
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // keep-alive every 20 cycles while hb_en is set
    initial begin
        hb_auto = 1'b0;
        hb_cnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            hb_cnt++;
            hb_auto = hb_en && (hb_cnt % 20 == 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench still running at %0t, required finish earlier", $time);
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] lvl, input logic dir);
        cmd_if.cmd_level = lvl;
        cmd_if.cmd_dir   = dir;
        cmd_if.cmd_valid = 1'b1;
        tick(1);
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_level = 2'd0;
        cmd_if.cmd_dir   = 1'b0;
        fault_in = 1'b0;
        fault_clr = 1'b0;
        hb_man = 1'b0;
        hb_en = 1'b1;
        tick(3);
        n_cmp++; if (psw !== 3'b000) begin n_err++; $display("FAIL reset_psw got %b want 000", psw); end
        n_cmp++; if (motor_en !== 1'b0) begin n_err++; $display("FAIL reset_motor_en got %b want 0", motor_en); end
        n_cmp++; if (cmd_if.cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready got %b want 1", cmd_if.cmd_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (fault_latched !== 1'b0) begin n_err++; $display("FAIL reset_fault_latched got %b want 0", fault_latched); end
        n_cmp++; if (fault_code !== 2'd0) begin n_err++; $display("FAIL reset_fault_code got %0d want 0", fault_code); end
        rst = 1'b0;
        tick(2);
        n_cmp++; if (state_dbg !== IDLE) begin n_err++; $display("FAIL reset_state got %0d want %0d", state_dbg, IDLE); end
    endtask

    task automatic test_ramp_up();
        send_cmd(2'd3, 1'b0);
        n_cmp++; if (state_dbg !== RAMP) begin n_err++; $display("FAIL up_state got %0d want %0d", state_dbg, RAMP); end
        n_cmp++; if ({psw, motor_en, busy, cmd_if.cmd_ready} !== 6'b000_110) begin n_err++; $display("FAIL up_entry psw/en/busy/rdy got %b want 000110", {psw, motor_en, busy, cmd_if.cmd_ready}); end
        tick(7);
        n_cmp++; if (psw !== 3'b000) begin n_err++; $display("FAIL up_early psw got %b want 000", psw); end
        tick(1);
        n_cmp++; if (psw !== 3'b001) begin n_err++; $display("FAIL up_lvl1 psw got %b want 001", psw); end
        tick(8);
        n_cmp++; if (psw !== 3'b010) begin n_err++; $display("FAIL up_lvl2 psw got %b want 010", psw); end
        tick(8);
        n_cmp++; if (psw !== 3'b011) begin n_err++; $display("FAIL up_lvl3 psw got %b want 011", psw); end
        n_cmp++; if (state_dbg !== RUN) begin n_err++; $display("FAIL up_run state got %0d want %0d", state_dbg, RUN); end
        n_cmp++; if ({busy, cmd_if.cmd_ready, motor_en} !== 3'b011) begin n_err++; $display("FAIL up_run busy/rdy/en got %b want 011", {busy, cmd_if.cmd_ready, motor_en}); end
    endtask

    task automatic test_reversal();
        int rdy_hi;
        int en_low;
        int dir_bad;
        rdy_hi = 0;
        en_low = 0;
        dir_bad = 0;
        send_cmd(2'd1, 1'b1);
        n_cmp++; if (state_dbg !== RAMP_DN) begin n_err++; $display("FAIL rev_state got %0d want %0d", state_dbg, RAMP_DN); end
        for (int i = 1; i <= 36; i++) begin
            tick(1);
            if (i < 36 && cmd_if.cmd_ready) rdy_hi++;
            if (i < 36 && psw[2] && psw[1:0] != 2'd0) dir_bad++;
            if (!motor_en) en_low++;
            case (i)
                8: begin
                    n_cmp++; if (psw !== 3'b010) begin n_err++; $display("FAIL rev_dn2 psw got %b want 010", psw); end
                end
                16: begin
                    n_cmp++; if (psw !== 3'b001) begin n_err++; $display("FAIL rev_dn1 psw got %b want 001", psw); end
                end
                24: begin
                    n_cmp++; if ({psw, motor_en} !== 4'b0000) begin n_err++; $display("FAIL rev_dead psw/en got %b want 0000", {psw, motor_en}); end
                    n_cmp++; if (state_dbg !== DEAD) begin n_err++; $display("FAIL rev_dead state got %0d want %0d", state_dbg, DEAD); end
                end
                28: begin
                    n_cmp++; if ({psw, motor_en} !== 4'b1001) begin n_err++; $display("FAIL rev_flip psw/en got %b want 1001", {psw, motor_en}); end
                    n_cmp++; if (state_dbg !== RAMP) begin n_err++; $display("FAIL rev_flip state got %0d want %0d", state_dbg, RAMP); end
                end
                36: begin
                    n_cmp++; if (psw !== 3'b101) begin n_err++; $display("FAIL rev_up psw got %b want 101", psw); end
                    n_cmp++; if ({state_dbg == RUN, busy} !== 2'b10) begin n_err++; $display("FAIL rev_run state=%0d busy=%b want RUN busy 0", state_dbg, busy); end
                end
                default: ;
            endcase
        end
        n_cmp++; if (rdy_hi !== 0) begin n_err++; $display("FAIL rev_ready cycles got %0d want 0", rdy_hi); end
        n_cmp++; if (en_low !== 4) begin n_err++; $display("FAIL rev_deadtime motor_en low cycles got %0d want 4", en_low); end
        n_cmp++; if (dir_bad !== 0) begin n_err++; $display("FAIL rev_dir dir=1 with nonzero level cycles got %0d want 0", dir_bad); end
    endtask

    task automatic test_held_cmd();
        send_cmd(2'd3, 1'b1);
        cmd_if.cmd_level = 2'd0;
        cmd_if.cmd_valid = 1'b1;
        tick(8);
        n_cmp++; if ({psw, cmd_if.cmd_ready} !== 4'b1100) begin n_err++; $display("FAIL held_ramp psw/rdy got %b want 1100", {psw, cmd_if.cmd_ready}); end
        tick(8);
        n_cmp++; if ({psw, cmd_if.cmd_ready} !== 4'b1111) begin n_err++; $display("FAIL held_run psw/rdy got %b want 1111", {psw, cmd_if.cmd_ready}); end
        n_cmp++; if (state_dbg !== RUN) begin n_err++; $display("FAIL held_run state got %0d want %0d", state_dbg, RUN); end
        tick(1);
        cmd_if.cmd_valid = 1'b0;
        n_cmp++; if ({psw, cmd_if.cmd_ready} !== 4'b1110) begin n_err++; $display("FAIL held_accept psw/rdy got %b want 1110", {psw, cmd_if.cmd_ready}); end
        n_cmp++; if (state_dbg !== RAMP) begin n_err++; $display("FAIL held_accept state got %0d want %0d", state_dbg, RAMP); end
        tick(8);
        n_cmp++; if (psw !== 3'b110) begin n_err++; $display("FAIL held_dn2 psw got %b want 110", psw); end
        tick(8);
        n_cmp++; if (psw !== 3'b101) begin n_err++; $display("FAIL held_dn1 psw got %b want 101", psw); end
        tick(8);
        n_cmp++; if ({psw, motor_en, busy, cmd_if.cmd_ready} !== 6'b100_001) begin n_err++; $display("FAIL held_idle psw/en/busy/rdy got %b want 100001", {psw, motor_en, busy, cmd_if.cmd_ready}); end
        n_cmp++; if (state_dbg !== IDLE) begin n_err++; $display("FAIL held_idle state got %0d want %0d", state_dbg, IDLE); end
    endtask

    task automatic test_fault_ext();
        send_cmd(2'd3, 1'b1);
        tick(8);
        n_cmp++; if (psw !== 3'b101) begin n_err++; $display("FAIL flt_pre psw got %b want 101", psw); end
        tick(4);
        fault_in = 1'b1;
        tick(1);
        n_cmp++; if (state_dbg !== FAULT) begin n_err++; $display("FAIL flt_state got %0d want %0d", state_dbg, FAULT); end
        n_cmp++; if ({psw, motor_en, fault_latched, cmd_if.cmd_ready, busy} !== 7'b100_0_1_0_0) begin n_err++; $display("FAIL flt_outs psw/en/lat/rdy/busy got %b want 1000100", {psw, motor_en, fault_latched, cmd_if.cmd_ready, busy}); end
        n_cmp++; if (fault_code !== 2'd1) begin n_err++; $display("FAIL flt_code got %0d want 1", fault_code); end
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        n_cmp++; if ({state_dbg == FAULT, fault_latched} !== 2'b11) begin n_err++; $display("FAIL flt_clr_ignored state=%0d latched=%b want FAULT 1", state_dbg, fault_latched); end
        fault_in = 1'b0;
        tick(3);
        n_cmp++; if ({state_dbg == FAULT, fault_code} !== 3'b101) begin n_err++; $display("FAIL flt_hold state=%0d code=%0d want FAULT 1", state_dbg, fault_code); end
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        n_cmp++; if (state_dbg !== IDLE) begin n_err++; $display("FAIL flt_exit state got %0d want %0d", state_dbg, IDLE); end
        n_cmp++; if ({psw, fault_latched, fault_code, cmd_if.cmd_ready} !== 7'b100_0_00_1) begin n_err++; $display("FAIL flt_exit psw/lat/code/rdy got %b want 1000001", {psw, fault_latched, fault_code, cmd_if.cmd_ready}); end
    endtask

    task automatic test_watchdog();
        // expiry after 64 silent cycles
        send_cmd(2'd1, 1'b1);
        tick(8);
        n_cmp++; if (state_dbg !== RUN) begin n_err++; $display("FAIL wd_run state got %0d want %0d", state_dbg, RUN); end
        hb_en = 1'b0;
        tick(2);
        hb_man = 1'b1;
        tick(1);
        hb_man = 1'b0;
        tick(63);
        n_cmp++; if (state_dbg !== RUN) begin n_err++; $display("FAIL wd_early state got %0d want %0d", state_dbg, RUN); end
        tick(1);
        n_cmp++; if ({state_dbg == FAULT, fault_code, motor_en, psw} !== 7'b1_10_0_100) begin n_err++; $display("FAIL wd_expire state=%0d code=%0d en=%b psw=%b want FAULT 2 0 100", state_dbg, fault_code, motor_en, psw); end
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        hb_en = 1'b1;
        n_cmp++; if ({state_dbg == IDLE, fault_code} !== 3'b100) begin n_err++; $display("FAIL wd_clr state=%0d code=%0d want IDLE 0", state_dbg, fault_code); end
        // heartbeat every 50 cycles keeps it alive
        send_cmd(2'd1, 1'b1);
        tick(8);
        hb_en = 1'b0;
        tick(2);
        for (int k = 0; k < 4; k++) begin
            hb_man = 1'b1;
            tick(1);
            hb_man = 1'b0;
            tick(49);
            n_cmp++; if (state_dbg !== RUN) begin n_err++; $display("FAIL wd_hb50_%0d state got %0d want %0d", k, state_dbg, RUN); end
        end
        // heartbeat on the expiry edge wins, then a fresh 64-cycle window
        hb_man = 1'b1;
        tick(1);
        hb_man = 1'b0;
        tick(63);
        hb_man = 1'b1;
        tick(1);
        hb_man = 1'b0;
        n_cmp++; if ({state_dbg == RUN, fault_latched} !== 2'b10) begin n_err++; $display("FAIL wd_same_edge state=%0d latched=%b want RUN 0", state_dbg, fault_latched); end
        tick(63);
        n_cmp++; if (state_dbg !== RUN) begin n_err++; $display("FAIL wd_reload state got %0d want %0d", state_dbg, RUN); end
        tick(1);
        n_cmp++; if ({state_dbg == FAULT, fault_code} !== 3'b110) begin n_err++; $display("FAIL wd_reload_expire state=%0d code=%0d want FAULT 2", state_dbg, fault_code); end
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        hb_en = 1'b1;
    endtask

    task automatic test_reset_async();
        send_cmd(2'd1, 1'b0);
        n_cmp++; if ({state_dbg == RAMP_DN, psw} !== 4'b1100) begin n_err++; $display("FAIL rst_rampdn state=%0d psw=%b want RAMP_DN 100", state_dbg, psw); end
        tick(9);
        n_cmp++; if ({state_dbg == DEAD, motor_en, busy} !== 3'b101) begin n_err++; $display("FAIL rst_dead state=%0d en=%b busy=%b want DEAD 0 1", state_dbg, motor_en, busy); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if ({psw, motor_en, busy, cmd_if.cmd_ready, fault_latched, fault_code} !== 9'b000_0_0_1_0_00) begin n_err++; $display("FAIL rst_async psw/en/busy/rdy/lat/code got %b want 000001000", {psw, motor_en, busy, cmd_if.cmd_ready, fault_latched, fault_code}); end
        n_cmp++; if (state_dbg !== IDLE) begin n_err++; $display("FAIL rst_async state got %0d want %0d", state_dbg, IDLE); end
        #1;
        rst = 1'b0;
        tick(2);
        n_cmp++; if ({state_dbg == IDLE, psw} !== 4'b1000) begin n_err++; $display("FAIL rst_after state=%0d psw=%b want IDLE 000", state_dbg, psw); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_ramp_up();
        test_reversal();
        test_held_cmd();
        test_fault_ext();
        test_watchdog();
        test_reset_async();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
